fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_W, default 32, instruction word width.
REQ-002 Parameter ADDR_W, default 32, PC width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-007 imem_addr  output  ADDR_W  fetch address; combinational instruction memory read.
REQ-008 imem_rdata  input  DATA_W  instruction at imem_addr, valid in the same cycle.
REQ-009 redirect  input  1  branch/jump taken; flush queue and refetch.
REQ-010 redirect_pc  input  ADDR_W  new fetch address, sampled when redirect=1.
REQ-011 stall_d  input  1  decode stage stalled; no entry consumed.
REQ-012 out_valid  output  1  head entry present.
REQ-013 out_instr  output  DATA_W  head instruction; all-zero (NOP) when out_valid=0.
REQ-014 out_pc  output  ADDR_W  PC of head instruction.
REQ-015 out_pcplus4  output  ADDR_W  out_pc + 4, modulo 2^ADDR_W.
REQ-016 count  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
REQ-017 full, empty  output  1 each  count==DEPTH, count==0.

Function
REQ-018 Circular buffer: write pointer, read pointer, occupancy counter; entries hold {pc, instr}.
REQ-019 imem_addr SHALL equal internal fetch_pc register at all times.
REQ-020 pop = out_valid & ~stall_d & ~redirect.
REQ-021 push = (~full | pop) & ~redirect; push writes {fetch_pc, imem_rdata} at write pointer and advances fetch_pc by 4 (wraps modulo 2^ADDR_W).
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-023 Pointers wrap modulo DEPTH with no bubble.
REQ-024 Push into an empty queue: entry visible on outputs the next cycle (1-cycle fetch-to-decode latency).
REQ-025 Outputs driven combinationally from head entry; out_valid = ~empty.
REQ-026 Full and no pop: fetch_pc holds, no write, imem_addr unchanged.
REQ-027 stall_d with empty queue SHALL have no effect; fills continue to DEPTH.
REQ-028 redirect=1: on the edge, count<=0, both pointers<=0, fetch_pc<=redirect_pc; no push, no pop that cycle regardless of stall_d or full.
REQ-029 Cycle after redirect: out_valid=0, imem_addr=redirect_pc; first redirected instruction valid the following cycle.
REQ-030 Back-to-back redirects: only the latest redirect_pc takes effect.
REQ-031 redirect_pc bits [1:0] are not checked; used as given.

Reset
REQ-032 reset=0 asynchronously forces fetch_pc=RESET_PC, pointers=0, count=0, regardless of clk.
REQ-033 During reset: out_valid=0, out_instr=0, empty=1, full=0, imem_addr=RESET_PC.
REQ-034 Entry storage need not be cleared; its contents are invisible while empty.
REQ-035 Reset asserted mid-operation SHALL discard all entries and any pending redirect.
REQ-036 First push on the first rising edge with reset=1.

Verification
REQ-037 Reset release, RESET_PC=0, stall_d=0, imem returns addr-derived words -> out_pc 0,4,8,... one per cycle from cycle 1, count stays 1.
REQ-038 stall_d=1 held 6 cycles, DEPTH=4 -> count 1,2,3,4,4,4; full=1; imem_addr frozen at 0x10; release -> out_pc 0,4,8,... in order, no loss or duplication.
REQ-039 Queue full, redirect=1 with redirect_pc=0x40 and stall_d=1 -> next cycle count=0, out_valid=0, imem_addr=0x40; cycle after, out_pc=0x40, out_pcplus4=0x44.
REQ-040 Full with stall_d=0 for 2*DEPTH cycles -> count stays DEPTH, pointers wrap, sequence unbroken.
REQ-041 reset driven low between clock edges while count=3 -> outputs cleared immediately, before the next edge; restart at RESET_PC.
REQ-042 fetch_pc=2^ADDR_W-4 -> next push PC wraps to 0; out_pcplus4 of the last entry is 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} entries between a
// combinational instruction memory and the decode stage, with redirect flush.
module fetch_queue #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     stall_d,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_instr,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [ADDR_W-1:0]        out_pcplus4,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Entry storage is deliberately left unreset; it is only visible when non-empty.
  logic [ADDR_W-1:0] entry_pc_q    [DEPTH];
  logic [DATA_W-1:0] entry_instr_q [DEPTH];

  logic full_c, empty_c, pop, push;

  always_comb begin
    full_c  = (count_q == CNT_W'(DEPTH));
    empty_c = (count_q == '0);
    pop     = ~empty_c & ~stall_d & ~redirect;
    push    = (~full_c | pop) & ~redirect;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_pc_q[wr_ptr_q]    <= fetch_pc_q;
      entry_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  always_comb begin
    imem_addr   = fetch_pc_q;
    count       = count_q;
    full        = full_c;
    empty       = empty_c;
    out_valid   = ~empty_c;
    out_instr   = empty_c ? '0 : entry_instr_q[rd_ptr_q];
    out_pc      = empty_c ? '0 : entry_pc_q[rd_ptr_q];
    out_pcplus4 = out_pc + ADDR_W'(4);
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue model predicts head entry, count
// and fetch address every cycle; the DUT is sampled on the falling edge.
module tb_fetch_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stall_d;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pcplus4;
  logic [$clog2(DEPTH):0] count;
  logic              full;
  logic              empty;

  entry_t            exp_q[$];
  logic [ADDR_W-1:0] m_fetch_pc;
  int                err_count   = 0;
  int                check_count = 0;

  fetch_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall_d(stall_d),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_pcplus4(out_pcplus4), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] instr_of(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
  endfunction

  assign imem_rdata = instr_of(imem_addr);

  task automatic check_output(input string tag, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [ADDR_W-1:0] exp_p4;
    check_output("count", 64'(count), 64'(exp_q.size()));
    check_output("imem_addr", 64'(imem_addr), 64'(m_fetch_pc));
    check_output("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    check_output("full", 64'(full), 64'(exp_q.size() == DEPTH));
    check_output("empty", 64'(empty), 64'(exp_q.size() == 0));
    if (exp_q.size() > 0) begin
      exp_p4 = exp_q[0].pc + 32'd4;
      check_output("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
      check_output("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
      check_output("out_pcplus4", 64'(out_pcplus4), 64'(exp_p4));
    end else begin
      check_output("out_instr_nop", 64'(out_instr), 64'd0);
    end
  endtask

  // Called on a falling edge: check current state, drive inputs, advance model.
  task automatic apply_stimulus(input logic st, input logic rd, input logic [ADDR_W-1:0] rpc);
    logic m_pop, m_push;
    compare_outputs();
    stall_d     = st;
    redirect    = rd;
    redirect_pc = rpc;
    m_pop  = (exp_q.size() > 0) && !st && !rd;
    m_push = ((exp_q.size() < DEPTH) || m_pop) && !rd;
    @(posedge clk);
    if (rd) begin
      exp_q.delete();
      m_fetch_pc = rpc;
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        exp_q.push_back('{pc: m_fetch_pc, instr: instr_of(m_fetch_pc)});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    stall_d     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    m_fetch_pc  = '0;
    #2;
    compare_outputs();
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] streaming with no stall");
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] decode stall fills queue");
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b0, '0);
    check_output("stall_full", 64'(full), 64'd1);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] redirect while full and stalled");
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, 32'h40);
    check_output("redir_addr", 64'(imem_addr), 64'h40);
    check_output("redir_valid", 64'(out_valid), 64'd0);
    apply_stimulus(1'b1, 1'b0, '0);
    check_output("redir_pc", 64'(out_pc), 64'h40);
    check_output("redir_pcp4", 64'(out_pcplus4), 64'h44);

    $display("[TB] full with continuous consumption");
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < 2 * DEPTH; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] back-to-back and unaligned redirects");
    apply_stimulus(1'b0, 1'b1, 32'h100);
    apply_stimulus(1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 32'h302);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] address wrap");
    apply_stimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, '0);
    check_output("wrap_pcp4", 64'(out_pcplus4), 64'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] asynchronous reset mid-cycle");
    apply_stimulus(1'b0, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, '0);
    check_output("pre_reset_count", 64'(count), 64'd3);
    reset = 1'b0;
    #1;
    exp_q.delete();
    m_fetch_pc = '0;
    compare_outputs();
    @(negedge clk);
    stall_d = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b0, '0);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++)
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
                     32'($urandom_range(0, 1023)) << 2);
    compare_outputs();

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
